// File: rtl/cart_mem_arb_if.sv
// Bundled CPU, loader and memory-port signals of the cartridge memory arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface cart_mem_arb_if #(
    parameter int unsigned AW = 17
);
    logic [AW-1:0] cpu_a;
    logic          cpu_rd;
    logic [7:0]    cpu_db;
    logic          cpu_rdy;
    logic          dl_active;
    logic          dl_req;
    logic [AW-1:0] dl_a;
    logic [7:0]    dl_d;
    logic          dl_ack;
    logic [AW-1:0] mem_a;
    logic [7:0]    mem_di;
    logic [7:0]    mem_do;
    logic          mem_rd;
    logic          mem_wr;
    logic          mem_rdy;

    modport slave (
        input  cpu_a, cpu_rd, dl_active, dl_req, dl_a, dl_d, mem_do, mem_rdy,
        output cpu_db, cpu_rdy, dl_ack, mem_a, mem_di, mem_rd, mem_wr
    );

    modport master (
        output cpu_a, cpu_rd, dl_active, dl_req, dl_a, dl_d, mem_do, mem_rdy,
        input  cpu_db, cpu_rdy, dl_ack, mem_a, mem_di, mem_rd, mem_wr
    );
endinterface

// File: rtl/cart_mem_arb.sv
// Arbitrates one fixed-latency cartridge memory port between CPU reads (priority) and
// loader writes. It also derives the cartridge mirror mask from the downloaded image size.
module cart_mem_arb #(
    parameter int unsigned AW  = 17,
    parameter int unsigned LAT = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    cart_mem_arb_if.slave       bus
);
    typedef enum logic [1:0] {StIdle, StRd, StRdWait, StWr} state_t;

    localparam logic [2:0] LatM1 = 3'(LAT - 1);

    state_t        r_state, w_state_d;
    logic          r_cpu_pend, w_cpu_pend_d;
    logic [AW-1:0] r_cpu_addr, w_cpu_addr;
    logic [2:0]    r_cnt, w_cnt_d;
    logic [AW-1:0] r_mem_a, w_mem_a_d;
    logic [7:0]    r_mem_di, w_mem_di_d;
    logic [7:0]    r_cpu_db, w_cpu_db_d;
    logic          r_cpu_rdy, w_cpu_rdy_d;
    logic          r_dl_active;
    logic [AW-1:0] r_acc, w_acc_d;
    logic [AW-1:0] w_mask;
    logic          w_pend;
    logic          w_dl_ack;
    logic          w_mem_rd;
    logic          w_mem_wr;

    // Fill every bit below the highest set accumulator bit.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < int'(AW); i++) begin
            w_mask[i] = |(r_acc >> i);
        end
    end

    // A CPU_RD in this very cycle counts as pending, so IDLE issues MEM_RD one cycle later.
    always_comb begin
        w_pend     = r_cpu_pend | bus.cpu_rd;
        w_cpu_addr = bus.cpu_rd ? (bus.cpu_a & w_mask) : r_cpu_addr;
    end

    always_comb begin
        w_state_d    = r_state;
        w_cpu_pend_d = w_pend;
        w_cnt_d      = r_cnt;
        w_mem_a_d    = r_mem_a;
        w_mem_di_d   = r_mem_di;
        w_cpu_db_d   = r_cpu_db;
        w_cpu_rdy_d  = 1'b0;
        w_dl_ack     = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_pend) begin
                    w_cpu_pend_d = 1'b0;
                    if (bus.dl_active) begin
                        w_cpu_db_d  = 8'hFF;
                        w_cpu_rdy_d = 1'b1;
                    end else begin
                        w_state_d = StRd;
                        w_mem_a_d = w_cpu_addr;
                    end
                end else if (bus.dl_req) begin
                    w_state_d  = StWr;
                    w_mem_a_d  = bus.dl_a;
                    w_mem_di_d = bus.dl_d;
                end
            end
            StRd: begin
                w_mem_rd = 1'b1;
                if (bus.mem_rdy) begin
                    w_state_d = StRdWait;
                    w_cnt_d   = LatM1;
                end
            end
            StRdWait: begin
                if (r_cnt == 3'd0) begin
                    w_cpu_db_d  = bus.mem_do;
                    w_cpu_rdy_d = 1'b1;
                    w_state_d   = StIdle;
                end else begin
                    w_cnt_d = r_cnt - 3'd1;
                end
            end
            StWr: begin
                w_mem_wr = 1'b1;
                if (bus.mem_rdy) begin
                    w_dl_ack  = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_acc_d = (bus.dl_active && !r_dl_active) ? '0 : r_acc;
        if (w_dl_ack) begin
            w_acc_d = w_acc_d | r_mem_a;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cpu_pend  <= 1'b0;
            r_cpu_addr  <= '0;
            r_cnt       <= '0;
            r_mem_a     <= '0;
            r_mem_di    <= '0;
            r_cpu_db    <= 8'hFF;
            r_cpu_rdy   <= 1'b0;
            r_dl_active <= 1'b0;
            r_acc       <= '1;
        end else begin
            r_state     <= w_state_d;
            r_cpu_pend  <= w_cpu_pend_d;
            r_cpu_addr  <= w_cpu_addr;
            r_cnt       <= w_cnt_d;
            r_mem_a     <= w_mem_a_d;
            r_mem_di    <= w_mem_di_d;
            r_cpu_db    <= w_cpu_db_d;
            r_cpu_rdy   <= w_cpu_rdy_d;
            r_dl_active <= bus.dl_active;
            r_acc       <= w_acc_d;
        end
    end

    assign bus.cpu_db  = r_cpu_db;
    assign bus.cpu_rdy = r_cpu_rdy;
    assign bus.dl_ack  = w_dl_ack;
    assign bus.mem_a   = r_mem_a;
    assign bus.mem_di  = r_mem_di;
    assign bus.mem_rd  = w_mem_rd;
    assign bus.mem_wr  = w_mem_wr;
endmodule

// File: tb/tb_cart_mem_arb.sv
// Scoreboard bench for cart_mem_arb. Directed stimulus pushes expected read data and memory
// read addresses, and a negedge monitor pops and compares them when the DUT presents them.
module tb_cart_mem_arb;
    localparam int unsigned AW  = 17;
    localparam int unsigned LAT = 2;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
    } ma_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ack_cnt = 0;
    int   last_ack_cyc = -1;
    int   both_cnt = 0;

    rd_exp_t rd_q[$];
    ma_exp_t ma_q[$];

    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_a = '0;
    logic [7:0]    pl_d = '0;
    logic [7:0]    mem [0:(1 << AW) - 1];
    logic [7:0]    pipe [LAT];

    cart_mem_arb_if #(.AW(AW)) bus ();

    cart_mem_arb #(.AW(AW), .LAT(LAT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data of an accepted read appears LAT cycles after the accept cycle.
    always @(posedge clk) begin
        if (pl_we) mem[pl_a] <= pl_d;
        if (bus.mem_wr && bus.mem_rdy) mem[bus.mem_a] <= bus.mem_di;
        pipe[0] <= (bus.mem_rd && bus.mem_rdy) ? mem[bus.mem_a] : 8'hEE;
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_do = pipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.cpu_rdy) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_cpu_rdy: got pulse data %0h want none (cycle %0d)",
                         bus.cpu_db, cyc);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check("cpu_db", 32'(bus.cpu_db), 32'(e.data));
                check("cpu_rdy_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (bus.mem_rd && bus.mem_rdy) begin
            if (ma_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_mem_rd: got addr %0h want none (cycle %0d)",
                         bus.mem_a, cyc);
            end else begin
                ma_exp_t m;
                m = ma_q.pop_front();
                check("mem_rd_addr", 32'(bus.mem_a), 32'(m.addr));
                check("mem_rd_cycle", 32'(cyc), 32'(m.cyc));
            end
        end
        if (bus.dl_ack) begin
            ack_cnt++;
            last_ack_cyc = cyc;
        end
        if (bus.mem_rd && bus.mem_wr) both_cnt++;
    end

    task automatic wait_done(input string name);
        int n = 0;
        while ((rd_q.size() != 0 || ma_q.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (rd_q.size() != 0 || ma_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d outstanding want 0", name,
                     rd_q.size() + ma_q.size());
            rd_q.delete();
            ma_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_ack(input string name, output bit ok);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.dl_ack && n < 20);
        ok = bus.dl_ack;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_ack_timeout: got no dl_ack want pulse", name);
        end
    endtask

    // Issues one CPU read; has_mem=0 means the fast 0xFF path with no memory access.
    task automatic cpu_read(input logic [AW-1:0] a, input logic [AW-1:0] exp_ma,
                            input logic [7:0] exp_d, input bit has_mem, input string name);
        int t0;
        @(posedge clk);
        #1;
        bus.cpu_rd = 1'b1;
        bus.cpu_a  = a;
        t0 = cyc;
        if (has_mem) ma_q.push_back('{addr: exp_ma, cyc: t0 + 1});
        rd_q.push_back('{data: exp_d, cyc: has_mem ? t0 + 2 + int'(LAT) : t0 + 1});
        @(posedge clk);
        #1;
        bus.cpu_rd = 1'b0;
        wait_done(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_db"}, 32'(bus.cpu_db), 32'hFF);
        check({tag, "_cpu_rdy"}, 32'(bus.cpu_rdy), 32'h0);
        check({tag, "_dl_ack"}, 32'(bus.dl_ack), 32'h0);
        check({tag, "_strobes"}, 32'({bus.mem_rd, bus.mem_wr}), 32'h0);
        check({tag, "_mem_a"}, 32'(bus.mem_a), 32'h0);
        check({tag, "_mem_di"}, 32'(bus.mem_di), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        int  ack0;
        bit  ok;

        bus.cpu_a = '0;
        bus.cpu_rd = 1'b0;
        bus.dl_active = 1'b0;
        bus.dl_req = 1'b0;
        bus.dl_a = '0;
        bus.dl_d = '0;
        bus.mem_rdy = 1'b1;

        // Reset and preload mem[0x0123] = 0x5A.
        repeat (3) @(posedge clk);
        #1;
        pl_we = 1'b1;
        pl_a = 17'h00123;
        pl_d = 8'h5A;
        @(posedge clk);
        #1;
        pl_we = 1'b0;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Basic read: MEM_RD at t0+1, data at t0+4, CPU_DB stays 0xFF before that.
        @(posedge clk);
        #1;
        bus.cpu_rd = 1'b1;
        bus.cpu_a = 17'h00123;
        t0 = cyc;
        ma_q.push_back('{addr: 17'h00123, cyc: t0 + 1});
        rd_q.push_back('{data: 8'h5A, cyc: t0 + 4});
        @(posedge clk);
        #1;
        bus.cpu_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("cpu_db_before_rdy", 32'(bus.cpu_db), 32'hFF);
        wait_done("basic_read");

        // Download an 8 KiB image, data = low address byte.
        #1;
        bus.dl_active = 1'b1;
        @(posedge clk);
        #1;
        ack0 = ack_cnt;
        for (int a = 0; a < 'h2000; a++) begin
            bus.dl_req = 1'b1;
            bus.dl_a = AW'(a);
            bus.dl_d = 8'(a);
            wait_ack("download", ok);
            @(posedge clk);
            #1;
            if (!ok) break;
        end
        bus.dl_req = 1'b0;
        bus.dl_active = 1'b0;
        check("dl_ack_count", 32'(ack_cnt - ack0), 32'h2000);
        repeat (2) @(posedge clk);

        // Mirror: 0x12345 masked by 0x1FFF reads 0x0345.
        cpu_read(17'h12345, 17'h00345, 8'h45, 1'b1, "mirror_read");

        // Collision: read first, write acknowledged one cycle after CPU_RDY.
        @(posedge clk);
        #1;
        bus.cpu_rd = 1'b1;
        bus.cpu_a = 17'h00345;
        bus.dl_req = 1'b1;
        bus.dl_a = 17'h00500;
        bus.dl_d = 8'h77;
        t0 = cyc;
        ack0 = ack_cnt;
        ma_q.push_back('{addr: 17'h00345, cyc: t0 + 1});
        rd_q.push_back('{data: 8'h45, cyc: t0 + 4});
        @(posedge clk);
        #1;
        bus.cpu_rd = 1'b0;
        wait_ack("collision", ok);
        @(posedge clk);
        #1;
        bus.dl_req = 1'b0;
        check("collision_ack_cycle", 32'(last_ack_cyc), 32'(t0 + 5));
        check("collision_ack_count", 32'(ack_cnt - ack0), 32'h1);
        wait_done("collision");
        cpu_read(17'h00500, 17'h00500, 8'h77, 1'b1, "collision_wr_readback");

        // Stall: MEM_RDY low cycles t0+1..t0+5, accept at t0+6, CPU_RDY at t0+9.
        @(posedge clk);
        #1;
        bus.cpu_rd = 1'b1;
        bus.cpu_a = 17'h00123;
        bus.mem_rdy = 1'b0;
        t0 = cyc;
        ma_q.push_back('{addr: 17'h00123, cyc: t0 + 6});
        rd_q.push_back('{data: 8'h23, cyc: t0 + 9});
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            bus.cpu_rd = 1'b0;
            check("stall_mem_rd", 32'(bus.mem_rd), 32'h1);
            check("stall_mem_a", 32'(bus.mem_a), 32'h00123);
        end
        @(posedge clk);
        #1;
        bus.mem_rdy = 1'b1;
        wait_done("stall");

        // Read during download: immediate 0xFF, no memory read.
        bus.dl_active = 1'b1;
        @(posedge clk);
        cpu_read(17'h00123, 17'h0, 8'hFF, 1'b0, "read_during_dl");
        #1;
        bus.dl_active = 1'b0;
        repeat (2) @(posedge clk);

        // Reset mid-read; the new download clears the mask, so address 0 is read.
        #1;
        bus.cpu_rd = 1'b1;
        bus.cpu_a = 17'h00001;
        t0 = cyc;
        ma_q.push_back('{addr: 17'h0, cyc: t0 + 1});
        @(posedge clk);
        #1;
        bus.cpu_rd = 1'b0;
        bus.dl_req = 1'b1;
        bus.dl_a = 17'h00600;
        bus.dl_d = 8'h99;
        ack0 = ack_cnt;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        wait_ack("post_reset", ok);
        @(posedge clk);
        #1;
        bus.dl_req = 1'b0;
        check("post_reset_ack_cycle", 32'(last_ack_cyc), 32'(t0 + 4));
        check("post_reset_ack_count", 32'(ack_cnt - ack0), 32'h1);
        repeat (4) @(posedge clk);
        #1;
        check("post_reset_cpu_db", 32'(bus.cpu_db), 32'hFF);
        cpu_read(17'h00600, 17'h00600, 8'h99, 1'b1, "post_reset_readback");

        check("both_strobes_cycles", 32'(both_cnt), 32'h0);
        check("queues_drained", 32'(rd_q.size() + ma_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
